ins_issue: RTL and testbench

//  Instruction issuer that drives the op_code/op_addr1/op_addr2 bus of the instruction decoder.

---
 rtl/ins_pkg.sv | 35 +++
 rtl/ins_if.sv | 16 +
 rtl/ins_fifo.sv | 66 ++++++
 rtl/ins_issue.sv | 136 +++++++++++++
 tb/tb_ins_issue.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ins_pkg.sv
// Shared definitions for the instruction issuer.
// Holds the instruction word layout, the opcode values, the FSM state type,
// and a helper that classifies opcodes the decoder cannot execute.
package ins_pkg;

  localparam int OP_W   = 5;
  localparam int ADDR_W = 16;
  localparam int INS_W  = 37;

  // Word layout: {op[36:32], addr1[31:16], addr2[15:0]}
  localparam int OP_MSB = 36;
  localparam int OP_LSB = 32;
  localparam int A1_MSB = 31;
  localparam int A1_LSB = 16;
  localparam int A2_MSB = 15;
  localparam int A2_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP     = 5'd0;
  localparam logic [OP_W-1:0] OP_MLB_WR  = 5'd1;
  localparam logic [OP_W-1:0] OP_MLB_RD  = 5'd2;
  localparam logic [OP_W-1:0] OP_PE_DIST = 5'd3;
  localparam logic [OP_W-1:0] OP_HALT    = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_e;

  // Opcodes 4..30 have no meaning to the decoder.
  function automatic logic op_unsupported(input logic [OP_W-1:0] op);
    return (op > OP_PE_DIST) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/ins_if.sv
// Host push channel into the instruction FIFO.
//   ins_valid : host word valid
//   ins_ready : issuer can accept a word
//   ins_data  : {op, addr1, addr2}
// master = host side, slave = issuer side.
interface ins_if;
  import ins_pkg::*;

  logic             ins_valid;
  logic             ins_ready;
  logic [INS_W-1:0] ins_data;

  modport master (output ins_valid, output ins_data, input ins_ready);
  modport slave  (input ins_valid, input ins_data, output ins_ready);

endinterface

// File: rtl/ins_fifo.sv
// Synchronous show-ahead FIFO holding instruction words.
//   clk, rst     : clock, asynchronous active-low reset (control state only)
//   push, pop    : write / read strobes, ignored when full / empty
//   wdata        : word to store
//   rdata        : oldest stored word, valid whenever !empty
//   count        : occupied entries
//   full, empty  : occupancy flags
module ins_fifo
  import ins_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [INS_W-1:0]             wdata,
  output logic [INS_W-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only pointers and count are flushed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ins_issue.sv
// Instruction issuer: queues host words and plays them onto the decoder bus.
//   clk, rst          : clock, asynchronous active-low reset
//   ins               : host push channel (ins_if.slave)
//   start             : single-cycle pulse that begins a run
//   op_code/op_addr1/op_addr2 : decoder bus, 0 = NOP
//   busy              : run in progress
//   done              : 1-cycle pulse at end of run
//   err_opcode        : 1-cycle pulse while an unsupported word is on the bus
//   fifo_count        : occupied FIFO entries
// Each word is held for its execution length, followed by one NOP cycle.
module ins_issue
  import ins_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MLB_BEATS = 32,
  parameter int PE_COLS   = 8,
  parameter int PE_STATES = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  ins_if.slave                        ins,
  input  logic                        start,
  output logic [OP_W-1:0]             op_code,
  output logic [ADDR_W-1:0]           op_addr1,
  output logic [ADDR_W-1:0]           op_addr2,
  output logic                        busy,
  output logic                        done,
  output logic                        err_opcode,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  localparam int PE_LEN  = PE_COLS * PE_STATES;
  localparam int MAX_LEN = (MLB_BEATS > PE_LEN) ? MLB_BEATS : PE_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  function automatic logic [CNT_W-1:0] hold_len(input logic [OP_W-1:0] op);
    case (op)
      OP_MLB_WR, OP_MLB_RD: return CNT_W'(MLB_BEATS);
      OP_PE_DIST:           return CNT_W'(PE_LEN);
      OP_HALT:              return '0;
      default:              return CNT_W'(1);
    endcase
  endfunction

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   op_code_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic              busy_q, done_q, err_q;

  logic [INS_W-1:0]  head;
  logic              full, empty, pop;
  logic [OP_W-1:0]   head_op;

  assign pop = !empty && (((state_q == ST_IDLE) && start) || (state_q == ST_GAP));
  assign head_op = head[OP_MSB:OP_LSB];
  assign ins.ins_ready = !full;

  ins_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ins.ins_valid),
    .pop   (pop),
    .wdata (ins.ins_data),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_code_q <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (pop) begin
        cnt_q <= hold_len(head_op);
        if (head_op == OP_HALT) begin
          // HALT ends the run at once; remaining words stay queued.
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          op_code_q <= '0;
          addr1_q   <= '0;
          addr2_q   <= '0;
        end else begin
          state_q   <= ST_ISSUE;
          busy_q    <= 1'b1;
          op_code_q <= op_unsupported(head_op) ? OP_NOP : head_op;
          err_q     <= op_unsupported(head_op);
          addr1_q   <= head[A1_MSB:A1_LSB];
          addr2_q   <= head[A2_MSB:A2_LSB];
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            // No pop here means the queue is empty: finish immediately.
            if (start) done_q <= 1'b1;
          end
          ST_ISSUE: begin
            if (cnt_q == CNT_W'(1)) begin
              state_q   <= ST_GAP;
              op_code_q <= '0;
              addr1_q   <= '0;
              addr2_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_GAP: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign op_code    = op_code_q;
  assign op_addr1   = addr1_q;
  assign op_addr2   = addr2_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_opcode = err_q;

endmodule

// File: tb/tb_ins_issue.sv
module tb_ins_issue;
  import ins_pkg::*;

  localparam int DEPTH = 8;
  localparam int MLB   = 32;
  localparam int PEC   = 8;
  localparam int PES   = 7;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic [4:0]                  op_code;
  logic [15:0]                 op_addr1, op_addr2;
  logic                        busy, done, err_opcode;
  logic [$clog2(DEPTH+1)-1:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  ins_if bus_if ();

  ins_issue #(
    .DEPTH(DEPTH), .MLB_BEATS(MLB), .PE_COLS(PEC), .PE_STATES(PES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (bus_if),
    .start      (start),
    .op_code    (op_code),
    .op_addr1   (op_addr1),
    .op_addr2   (op_addr2),
    .busy       (busy),
    .done       (done),
    .err_opcode (err_opcode),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] mkw(input logic [4:0] op, input logic [15:0] a1, input logic [15:0] a2);
    return {op, a1, a2};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [36:0] w);
    bus_if.ins_valid = 1'b1;
    bus_if.ins_data  = w;
    tick();
    bus_if.ins_valid = 1'b0;
  endtask

  // Returns at the negedge where the first issued word is visible.
  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic hold(input string tag, input logic [4:0] op, input logic [15:0] a1,
                      input logic [15:0] a2, input int len);
    int bad = 0;
    for (int i = 0; i < len; i++) begin
      if (op_code !== op || op_addr1 !== a1 || op_addr2 !== a2 || busy !== 1'b1) bad++;
      tick();
    end
    chk(tag, bad, 0);
  endtask

  task automatic gap(input string tag);
    chk(tag, {op_code, op_addr1, op_addr2, busy}, {5'd0, 16'd0, 16'd0, 1'b1});
    tick();
  endtask

  task automatic expect_done(input string tag);
    chk({tag, " done"}, {done, busy}, 2'b10);
    tick();
    chk({tag, " done clr"}, done, 1'b0);
  endtask

  initial begin
    int ndone;
    rst = 1'b0;
    start = 1'b0;
    bus_if.ins_valid = 1'b0;
    bus_if.ins_data = '0;
    repeat (2) tick();
    chk("rst bus", {op_code, op_addr1, op_addr2}, 37'd0);
    chk("rst flags", {busy, done, err_opcode, bus_if.ins_ready}, 4'b0001);
    chk("rst count", fifo_count, 0);
    rst = 1'b1;
    tick();

    // Start with nothing queued: done only.
    start_pulse();
    chk("empty start", {done, busy}, 2'b10);
    tick();
    chk("empty start clr", done, 1'b0);

    // 1: single MLB write
    push(mkw(5'd1, 16'h0010, 16'h0020));
    chk("t1 count", fifo_count, 1);
    start_pulse();
    hold("t1 hold", 5'd1, 16'h0010, 16'h0020, 32);
    gap("t1 gap");
    expect_done("t1");

    // 2: PE distribute then MLB read
    push(mkw(5'd3, 16'h0300, 16'h0301));
    push(mkw(5'd2, 16'h0200, 16'h0201));
    start_pulse();
    hold("t2 hold3", 5'd3, 16'h0300, 16'h0301, 56);
    gap("t2 gap3");
    hold("t2 hold2", 5'd2, 16'h0200, 16'h0201, 32);
    gap("t2 gap2");
    expect_done("t2");

    // 3: fill FIFO, hold a push while full
    for (int k = 0; k < DEPTH; k++) push(mkw(5'd0, 16'(16'h0A00 + k), 16'(16'h0B00 + k)));
    chk("t3 full", {bus_if.ins_ready, 4'(fifo_count)}, {1'b0, 4'(DEPTH)});
    bus_if.ins_valid = 1'b1;
    bus_if.ins_data  = mkw(5'd1, 16'h0C0C, 16'h0D0D);
    start_pulse();
    chk("t3 first pop", {op_code, op_addr1, op_addr2, 4'(fifo_count), bus_if.ins_ready},
        {5'd0, 16'h0A00, 16'h0B00, 4'd7, 1'b1});
    tick();
    chk("t3 held push", fifo_count, DEPTH);
    bus_if.ins_valid = 1'b0;
    gap("t3 gap0");
    for (int k = 1; k < DEPTH; k++) begin
      hold("t3 hold", 5'd0, 16'(16'h0A00 + k), 16'(16'h0B00 + k), 1);
      gap("t3 gap");
    end
    hold("t3 late word", 5'd1, 16'h0C0C, 16'h0D0D, 32);
    gap("t3 gap last");
    expect_done("t3");

    // 4: unsupported opcode then MLB write
    push(mkw(5'd7, 16'h0707, 16'h0708));
    push(mkw(5'd1, 16'h0101, 16'h0102));
    start_pulse();
    chk("t4 err cycle", {op_code, op_addr1, op_addr2, err_opcode, busy},
        {5'd0, 16'h0707, 16'h0708, 1'b1, 1'b1});
    tick();
    chk("t4 err clr", err_opcode, 1'b0);
    gap("t4 gap");
    hold("t4 hold", 5'd1, 16'h0101, 16'h0102, 32);
    gap("t4 gap1");
    expect_done("t4");

    // 5: HALT stops the run, remaining word kept
    push(mkw(5'd2, 16'h0222, 16'h0223));
    push(mkw(5'd31, 16'h0F0F, 16'h0F0F));
    push(mkw(5'd1, 16'h0111, 16'h0112));
    start_pulse();
    hold("t5 hold2", 5'd2, 16'h0222, 16'h0223, 32);
    gap("t5 gap");
    chk("t5 halt bus", {op_code, op_addr1, op_addr2}, 37'd0);
    expect_done("t5");
    chk("t5 count", fifo_count, 1);
    start_pulse();
    hold("t5 resume", 5'd1, 16'h0111, 16'h0112, 32);
    gap("t5 gap1");
    expect_done("t5b");
    chk("t5 drained", fifo_count, 0);

    // 6: asynchronous reset mid-hold
    push(mkw(5'd1, 16'h0616, 16'h0626));
    push(mkw(5'd2, 16'h0636, 16'h0646));
    start_pulse();
    repeat (10) tick();
    chk("t6 pre", op_code, 5'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6 async bus", {op_code, op_addr1, op_addr2}, 37'd0);
    chk("t6 async flags", {busy, done, err_opcode, bus_if.ins_ready}, 4'b0001);
    chk("t6 async count", fifo_count, 0);
    tick();
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
      tick();
    end
    chk("t6 no done", ndone, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
